common_dffcam_alloc_ctrl: RTL and testbench
===========================================

# common_dffcam_alloc_ctrl

Lookup-or-allocate controller sitting directly upstream of the 1-address/1-write/1-read/1-query DFF CAM. It accepts key requests over a valid/ready handshake and queries the CAM. On a hit it returns the matching index; on a miss it picks a victim entry, writes the key into the CAM, and returns the allocated index. It is the sole writer of the CAM it drives. It also accepts entry-release (invalidate) requests.

## Interface
Parameters:
- CAM_DEPTH, 8, number of CAM entries; any value ≥ 2, not necessarily a power of two.
- CAM_WIDTH, 8, key width.
- IDX_WIDTH (localparam), $clog2(CAM_DEPTH), binary index width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid / req_ready  in / out  1  request handshake.
- req_key  in  CAM_WIDTH  key to look up.
- resp_valid / resp_ready  out / in  1  response handshake.
- resp_idx  out  IDX_WIDTH  hit or allocated entry.
- resp_hit  out  1  1 = existing entry matched.
- resp_evict  out  1  1 = allocation overwrote a valid entry.
- rel_valid / rel_ready  in / out  1  release handshake.
- rel_idx  in  IDX_WIDTH  entry to invalidate.
- cam_addr  out  IDX_WIDTH  binary CAM address (CAM configured with binary addressing and binary query output).
- cam_en, cam_we  out  1  CAM write strobe (both driven identically).
- cam_din  out  CAM_WIDTH  write data.
- cam_din_valid  out  1  write valid bit.
- cam_qdata  out  CAM_WIDTH  query key.
- cam_qaddr  in  IDX_WIDTH  query result index.
- cam_qvalid  in  1  query hit.

## Operation
- The CAM instance uses a zero valid-reset value. The block keeps a CAM_DEPTH-bit mirror `vmask` of CAM valid bits (reset all 0).
- FSM states: IDLE, LOOKUP, ALLOC, RESP. Reset state is IDLE.
- IDLE:
  - req_ready = 1 (forced 0 while reset is high).
  - On req_valid, latch key_q ← req_key and go to LOOKUP.
- LOOKUP:
  - cam_qdata = key_q (cam_qdata = key_q in every state).
  - If cam_qvalid and the hit is not cancelled: latch idx ← cam_qaddr, hit ← 1, evict ← 0, go to RESP.
  - Otherwise go to ALLOC.
- ALLOC:
  - Select victim v. Drive cam_en = cam_we = 1, cam_addr = v, cam_din = key_q, cam_din_valid = 1.
  - Set vmask[v]. Latch idx ← v, hit ← 0, evict ← old vmask[v]. Go to RESP.
- RESP:
  - resp_valid = 1 with stable idx/hit/evict until resp_ready, then go to IDLE.
- Release:
  - rel_ready = (state != ALLOC).
  - On rel_valid & rel_ready: cam_en = cam_we = 1, cam_addr = rel_idx, cam_din = 0, cam_din_valid = 0, and clear vmask[rel_idx].
  - Releasing an already-invalid entry is legal and has no further effect.
- Hit cancel: a release fire in the LOOKUP cycle with rel_idx == cam_qaddr turns that hit into a miss, leading to ALLOC.
- A release of resp_idx during RESP does not alter the pending response.
- Victim pointer `ptr`:
  - Resets to 0.
  - Increments by 1, wrapping CAM_DEPTH-1 → 0, only when the victim was taken from ptr.

## Timing
- Request accepted at cycle 0.
  - Hit: resp_valid asserted at cycle 2.
  - Miss: CAM write occurs in cycle 2, the written entry is visible to queries from cycle 3, and resp_valid is asserted at cycle 3.
- Best-case throughput: one request per 3 cycles (hit) or 4 cycles (miss), given resp_ready held at 1.
- Outputs while reset is high: req_ready 0, resp_valid 0, cam_en/cam_we 0, cam_din 0, cam_din_valid 0, resp_* 0, rel_ready 0.
- Reset asserted mid-operation:
  - Any in-flight request is dropped. No CAM write occurs after the asserting edge.
  - vmask and ptr clear. The CAM itself is reset by the same signal.
- Release and request handshakes are independent. A release can fire in the same cycle a request is accepted.

## Configuration
- Macro COMMON_DFFCAM_ALLOC_FREE_FIRST_EN.
- Defined: if vmask has any 0 bit, the victim is the lowest-index invalid entry (evict = 0) and ptr is unchanged. Otherwise the victim is ptr.
- Undefined: the victim is always ptr (pure round-robin). vmask is still maintained for resp_evict.

## Structure
- Package common_dffcam_alloc_pkg holds:
  - the FSM state encoding (2-bit IDLE=0, LOOKUP=1, ALLOC=2, RESP=3);
  - the IDX_WIDTH computation helper.
- One sub-module, common_dffcam_alloc_victim: inputs vmask and ptr; outputs victim index and a `from_ptr` flag. It contains the lowest-zero priority encoder under the macro. This module is purely combinational.
- ptr and vmask registers live in the top module.

## Test plan
CAM_DEPTH = 4 and CAM_WIDTH = 8 unless stated.
- After reset, request 0x11 → resp at cycle 3: idx 0, hit 0, evict 0. Then request 0x11 → resp at cycle 2: idx 0, hit 1.
- Requests 0x11, 0x22, 0x33, 0x44 → idx 0, 1, 2, 3 with evict 0. Then request 0x55 → idx 0, evict 1. Then request 0x11 → miss, idx 1, evict 1.
- After 5 allocations (ptr = 1), release idx 2, then request 0x66:
  - macro undefined → idx 1, evict 1;
  - macro defined → idx 2, evict 0, ptr stays 1.
- 0x22 stored at idx 1. Request 0x22 and fire release idx 1 in the LOOKUP cycle → miss, ALLOC writes 0x22, resp hit 0.
- Miss response with resp_ready held low 5 cycles → resp fields stable, req_ready 0, exactly one CAM write pulse. Release attempted during ALLOC → rel_ready 0, accepted the next cycle.
- Assert reset during the ALLOC cycle → all outputs 0 immediately, no CAM write. After deassert, request 0x77 → miss, idx 0, evict 0.

Source files
------------

// File: rtl/common_dffcam_alloc_pkg.sv
// Shared FSM state encoding and index-width helper for the DFF CAM
// lookup-or-allocate controller.
package common_dffcam_alloc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_ALLOC  = 2'd2,
        ST_RESP   = 2'd3
    } alloc_state_t;

    function automatic int calc_idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/common_dffcam_alloc_victim.sv
// Combinational victim selection for the allocation controller. With
// COMMON_DFFCAM_ALLOC_FREE_FIRST_EN defined, the lowest invalid entry beats the round-robin pointer.
module common_dffcam_alloc_victim
    import common_dffcam_alloc_pkg::*;
#(
    parameter int CAM_DEPTH = 8,
    parameter int IDX_WIDTH = calc_idx_width(CAM_DEPTH)
) (
    input  logic [CAM_DEPTH-1:0] vmask,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] victim,
    output logic                 from_ptr
);

`ifdef COMMON_DFFCAM_ALLOC_FREE_FIRST_EN
    always_comb begin
        victim   = ptr;
        from_ptr = 1'b1;
        // Scan downward so the lowest-index free entry is the last one written.
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (!vmask[i]) begin
                victim   = IDX_WIDTH'(i);
                from_ptr = 1'b0;
            end
        end
    end
`else
    logic unused_vmask;

    assign unused_vmask = ^vmask;
    assign victim       = ptr;
    assign from_ptr     = 1'b1;
`endif

endmodule

// File: rtl/common_dffcam_alloc_ctrl.sv
// Lookup-or-allocate controller and sole writer of a binary-addressed DFF CAM.
// Victim policy is selected by COMMON_DFFCAM_ALLOC_FREE_FIRST_EN (see common_dffcam_alloc_victim).
module common_dffcam_alloc_ctrl
    import common_dffcam_alloc_pkg::*;
#(
    parameter  int CAM_DEPTH = 8,
    parameter  int CAM_WIDTH = 8,
    localparam int IDX_WIDTH = calc_idx_width(CAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CAM_WIDTH-1:0] req_key,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDX_WIDTH-1:0] resp_idx,
    output logic                 resp_hit,
    output logic                 resp_evict,
    input  logic                 rel_valid,
    output logic                 rel_ready,
    input  logic [IDX_WIDTH-1:0] rel_idx,
    output logic [IDX_WIDTH-1:0] cam_addr,
    output logic                 cam_en,
    output logic                 cam_we,
    output logic [CAM_WIDTH-1:0] cam_din,
    output logic                 cam_din_valid,
    output logic [CAM_WIDTH-1:0] cam_qdata,
    input  logic [IDX_WIDTH-1:0] cam_qaddr,
    input  logic                 cam_qvalid
);

    alloc_state_t         state;
    alloc_state_t         state_next;
    logic [CAM_WIDTH-1:0] key_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic                 hit_q;
    logic                 evict_q;
    logic [IDX_WIDTH-1:0] ptr;
    logic [CAM_DEPTH-1:0] vmask;
    logic [CAM_DEPTH-1:0] vmask_next;
    logic [IDX_WIDTH-1:0] victim;
    logic                 from_ptr;
    logic                 victim_valid;
    logic                 rel_fire;
    logic                 hit_cancel;
    logic                 lookup_hit;

    common_dffcam_alloc_victim #(
        .CAM_DEPTH (CAM_DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_victim (
        .vmask    (vmask),
        .ptr      (ptr),
        .victim   (victim),
        .from_ptr (from_ptr)
    );

    assign req_ready  = !reset && (state == ST_IDLE);
    assign rel_ready  = !reset && (state != ST_ALLOC);
    assign resp_valid = !reset && (state == ST_RESP);
    assign resp_idx   = idx_q;
    assign resp_hit   = hit_q;
    assign resp_evict = evict_q;
    assign cam_qdata  = key_q;
    assign cam_we     = cam_en;

    assign rel_fire   = rel_valid && rel_ready;
    // A release that lands on the entry being hit makes the match stale.
    assign hit_cancel = rel_fire && (rel_idx == cam_qaddr);
    assign lookup_hit = cam_qvalid && !hit_cancel;

    always_comb begin
        victim_valid = 1'b0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            if (victim == IDX_WIDTH'(i)) begin
                victim_valid = vmask[i];
            end
        end
    end

    always_comb begin
        vmask_next = vmask;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            if ((state == ST_ALLOC) && (victim == IDX_WIDTH'(i))) begin
                vmask_next[i] = 1'b1;
            end
            if (rel_fire && (rel_idx == IDX_WIDTH'(i))) begin
                vmask_next[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_next    = state;
        cam_en        = 1'b0;
        cam_addr      = '0;
        cam_din       = '0;
        cam_din_valid = 1'b0;
        case (state)
            ST_IDLE:   if (req_valid) state_next = ST_LOOKUP;
            ST_LOOKUP: state_next = lookup_hit ? ST_RESP : ST_ALLOC;
            ST_ALLOC:  state_next = ST_RESP;
            ST_RESP:   if (resp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // Allocation write and release write never coincide: releases stall in ALLOC.
        if (state == ST_ALLOC) begin
            cam_en        = 1'b1;
            cam_addr      = victim;
            cam_din       = key_q;
            cam_din_valid = 1'b1;
        end else if (rel_fire) begin
            cam_en   = 1'b1;
            cam_addr = rel_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            evict_q <= 1'b0;
            ptr     <= '0;
            vmask   <= '0;
        end else begin
            state <= state_next;
            vmask <= vmask_next;
            if ((state == ST_IDLE) && req_valid) begin
                key_q <= req_key;
            end
            if ((state == ST_LOOKUP) && lookup_hit) begin
                idx_q   <= cam_qaddr;
                hit_q   <= 1'b1;
                evict_q <= 1'b0;
            end
            if (state == ST_ALLOC) begin
                idx_q   <= victim;
                hit_q   <= 1'b0;
                evict_q <= victim_valid;
                if (from_ptr) begin
                    ptr <= (ptr == IDX_WIDTH'(CAM_DEPTH - 1)) ? '0 : ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_common_dffcam_alloc_ctrl.sv
// Self-checking bench for common_dffcam_alloc_ctrl with a behavioural CAM and a
// table-based reference model; honours COMMON_DFFCAM_ALLOC_FREE_FIRST_EN when defined.
module tb_common_dffcam_alloc_ctrl;

    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int IW    = 2;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_key;
    logic          resp_valid;
    logic          resp_ready;
    logic [IW-1:0] resp_idx;
    logic          resp_hit;
    logic          resp_evict;
    logic          rel_valid;
    logic          rel_ready;
    logic [IW-1:0] rel_idx;
    logic [IW-1:0] cam_addr;
    logic          cam_en;
    logic          cam_we;
    logic [W-1:0]  cam_din;
    logic          cam_din_valid;
    logic [W-1:0]  cam_qdata;
    logic [IW-1:0] cam_qaddr;
    logic          cam_qvalid;

    int vectors;
    int miscompares;

    logic [W-1:0] m_key [DEPTH];
    bit           m_vld [DEPTH];
    int           m_ptr;

    logic [W-1:0] cam_key [DEPTH];
    logic         cam_vld [DEPTH];

    common_dffcam_alloc_ctrl #(
        .CAM_DEPTH (DEPTH),
        .CAM_WIDTH (W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_idx      (resp_idx),
        .resp_hit      (resp_hit),
        .resp_evict    (resp_evict),
        .rel_valid     (rel_valid),
        .rel_ready     (rel_ready),
        .rel_idx       (rel_idx),
        .cam_addr      (cam_addr),
        .cam_en        (cam_en),
        .cam_we        (cam_we),
        .cam_din       (cam_din),
        .cam_din_valid (cam_din_valid),
        .cam_qdata     (cam_qdata),
        .cam_qaddr     (cam_qaddr),
        .cam_qvalid    (cam_qvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DFF CAM: registered write, combinational lowest-index query.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cam_vld[i] <= 1'b0;
                cam_key[i] <= '0;
            end
        end else if (cam_we) begin
            cam_key[cam_addr] <= cam_din;
            cam_vld[cam_addr] <= cam_din_valid;
        end
    end

    always_comb begin
        cam_qvalid = 1'b0;
        cam_qaddr  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cam_vld[i] && (cam_key[i] == cam_qdata)) begin
                cam_qvalid = 1'b1;
                cam_qaddr  = IW'(i);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 1'b0;
            m_key[i] = '0;
        end
        m_ptr = 0;
    endtask

    task automatic model_release(input int i);
        m_vld[i] = 1'b0;
    endtask

    task automatic model_request(input logic [W-1:0] key, output logic [IW-1:0] e_idx,
                                 output logic e_hit, output logic e_evict, output int e_lat);
        int  v;
        bit  bump;
        e_hit   = 1'b0;
        e_idx   = '0;
        e_evict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && m_key[i] == key) begin
                e_hit = 1'b1;
                e_idx = IW'(i);
            end
        end
        if (e_hit) begin
            e_lat = 2;
            return;
        end
        v    = m_ptr;
        bump = 1'b1;
`ifdef COMMON_DFFCAM_ALLOC_FREE_FIRST_EN
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!m_vld[i]) begin
                v    = i;
                bump = 1'b0;
            end
        end
`endif
        e_idx    = IW'(v);
        e_evict  = m_vld[v];
        m_key[v] = key;
        m_vld[v] = 1'b1;
        if (bump) m_ptr = (m_ptr + 1) % DEPTH;
        e_lat = 3;
    endtask

    task automatic apply_reset;
        reset      = 1'b1;
        req_valid  = 1'b0;
        rel_valid  = 1'b0;
        resp_ready = 1'b0;
        req_key    = '0;
        rel_idx    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick;
        model_reset();
    endtask

    // Drives one request (optionally with a same-cycle release); lat = -1 on timeout.
    task automatic issue_request(input logic [W-1:0] key, input int delay, input bit rel_en,
                                 input logic [IW-1:0] rel_i, output int lat,
                                 output logic [IW-1:0] idx, output logic hit, output logic evict);
        req_key    = key;
        req_valid  = 1'b1;
        rel_valid  = rel_en;
        rel_idx    = rel_i;
        resp_ready = (delay == 0);
        tick;
        req_valid = 1'b0;
        rel_valid = 1'b0;
        lat       = 1;
        while (!resp_valid && lat < 20) begin
            tick;
            lat++;
        end
        if (!resp_valid) begin
            lat   = -1;
            idx   = 'x;
            hit   = 1'bx;
            evict = 1'bx;
            return;
        end
        idx   = resp_idx;
        hit   = resp_hit;
        evict = resp_evict;
        repeat (delay) tick;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    task automatic do_release(input logic [IW-1:0] i);
        rel_idx   = i;
        rel_valid = 1'b1;
        tick;
        rel_valid = 1'b0;
        model_release(int'(i));
    endtask

    task automatic test_reset;
        logic [23:0] obs;
        reset      = 1'b1;
        req_valid  = 1'b1;
        rel_valid  = 1'b1;
        resp_ready = 1'b1;
        req_key    = 8'hAA;
        rel_idx    = 2'd1;
        tick;
        obs = {req_ready, resp_valid, cam_en, cam_we, cam_din, cam_din_valid, rel_ready,
               resp_idx, resp_hit, resp_evict, 6'd0};
        vectors++;
        if (obs !== 24'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h, expected 000000", obs);
        end
        apply_reset();
        vectors++;
        if ({req_ready, rel_ready, resp_valid} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL post_reset_ready: got %b, expected 110", {req_ready, rel_ready, resp_valid});
        end
    endtask

    task automatic test_first_alloc;
        int lat, e_lat;
        logic [IW-1:0] idx, e_idx;
        logic hit, evict, e_hit, e_evict;
        for (int n = 0; n < 2; n++) begin
            model_request(8'h11, e_idx, e_hit, e_evict, e_lat);
            issue_request(8'h11, 0, 1'b0, '0, lat, idx, hit, evict);
            vectors += 4;
            if (lat !== e_lat) begin miscompares++; $display("[TB] FAIL first_lat[%0d]: got %0d, expected %0d", n, lat, e_lat); end
            if (idx !== e_idx) begin miscompares++; $display("[TB] FAIL first_idx[%0d]: got %0d, expected %0d", n, idx, e_idx); end
            if (hit !== e_hit) begin miscompares++; $display("[TB] FAIL first_hit[%0d]: got %b, expected %b", n, hit, e_hit); end
            if (evict !== e_evict) begin miscompares++; $display("[TB] FAIL first_evict[%0d]: got %b, expected %b", n, evict, e_evict); end
        end
    endtask

    task automatic test_fill_evict;
        logic [W-1:0] keys [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h11};
        int lat, e_lat;
        logic [IW-1:0] idx, e_idx;
        logic hit, evict, e_hit, e_evict;
        for (int n = 0; n < 5; n++) begin
            model_request(keys[n], e_idx, e_hit, e_evict, e_lat);
            issue_request(keys[n], 0, 1'b0, '0, lat, idx, hit, evict);
            vectors += 4;
            if (lat !== e_lat) begin miscompares++; $display("[TB] FAIL fill_lat[%0d]: got %0d, expected %0d", n, lat, e_lat); end
            if (idx !== e_idx) begin miscompares++; $display("[TB] FAIL fill_idx[%0d]: got %0d, expected %0d", n, idx, e_idx); end
            if (hit !== e_hit) begin miscompares++; $display("[TB] FAIL fill_hit[%0d]: got %b, expected %b", n, hit, e_hit); end
            if (evict !== e_evict) begin miscompares++; $display("[TB] FAIL fill_evict[%0d]: got %b, expected %b", n, evict, e_evict); end
        end
    endtask

    task automatic test_release_victim;
        logic [W-1:0] keys [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        int lat, e_lat;
        logic [IW-1:0] idx, e_idx;
        logic hit, evict, e_hit, e_evict;
        apply_reset();
        for (int n = 0; n < 7; n++) begin
            if (n == 5) do_release(2'd2);
            model_request(keys[n], e_idx, e_hit, e_evict, e_lat);
            issue_request(keys[n], 0, 1'b0, '0, lat, idx, hit, evict);
            vectors += 4;
            if (lat !== e_lat) begin miscompares++; $display("[TB] FAIL relv_lat[%0d]: got %0d, expected %0d", n, lat, e_lat); end
            if (idx !== e_idx) begin miscompares++; $display("[TB] FAIL relv_idx[%0d]: got %0d, expected %0d", n, idx, e_idx); end
            if (hit !== e_hit) begin miscompares++; $display("[TB] FAIL relv_hit[%0d]: got %b, expected %b", n, hit, e_hit); end
            if (evict !== e_evict) begin miscompares++; $display("[TB] FAIL relv_evict[%0d]: got %b, expected %b", n, evict, e_evict); end
        end
    endtask

    task automatic test_hit_cancel;
        int lat, e_lat;
        logic [IW-1:0] idx, e_idx;
        logic hit, evict, e_hit, e_evict;
        apply_reset();
        model_request(8'h11, e_idx, e_hit, e_evict, e_lat);
        issue_request(8'h11, 0, 1'b0, '0, lat, idx, hit, evict);
        model_request(8'h22, e_idx, e_hit, e_evict, e_lat);
        issue_request(8'h22, 0, 1'b0, '0, lat, idx, hit, evict);
        model_release(1);
        model_request(8'h22, e_idx, e_hit, e_evict, e_lat);
        req_key    = 8'h22;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        tick;
        req_valid = 1'b0;
        rel_idx   = 2'd1;
        rel_valid = 1'b1;
        #1;
        vectors++;
        if (rel_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL cancel_rel_ready: got %b, expected 1", rel_ready); end
        tick;
        rel_valid = 1'b0;
        lat = 2;
        while (!resp_valid && lat < 20) begin
            tick;
            lat++;
        end
        vectors += 4;
        if (lat !== e_lat) begin miscompares++; $display("[TB] FAIL cancel_lat: got %0d, expected %0d", lat, e_lat); end
        if (resp_idx !== e_idx) begin miscompares++; $display("[TB] FAIL cancel_idx: got %0d, expected %0d", resp_idx, e_idx); end
        if (resp_hit !== e_hit) begin miscompares++; $display("[TB] FAIL cancel_hit: got %b, expected %b", resp_hit, e_hit); end
        if (resp_evict !== e_evict) begin miscompares++; $display("[TB] FAIL cancel_evict: got %b, expected %b", resp_evict, e_evict); end
        tick;
        resp_ready = 1'b0;
        model_request(8'h22, e_idx, e_hit, e_evict, e_lat);
        issue_request(8'h22, 0, 1'b0, '0, lat, idx, hit, evict);
        vectors += 2;
        if (idx !== e_idx) begin miscompares++; $display("[TB] FAIL cancel_rehit_idx: got %0d, expected %0d", idx, e_idx); end
        if (hit !== e_hit) begin miscompares++; $display("[TB] FAIL cancel_rehit_hit: got %b, expected %b", hit, e_hit); end
    endtask

    task automatic test_backpressure;
        int lat, e_lat, writes;
        logic [IW-1:0] idx, e_idx;
        logic hit, evict, e_hit, e_evict;
        writes = 0;
        model_request(8'hA5, e_idx, e_hit, e_evict, e_lat);
        req_key    = 8'hA5;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        tick;
        req_valid = 1'b0;
        if (cam_we && cam_din_valid) writes++;
        tick;
        rel_idx   = e_idx;
        rel_valid = 1'b1;
        #1;
        vectors++;
        if (rel_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_rel_ready_alloc: got %b, expected 0", rel_ready); end
        if (cam_we && cam_din_valid) writes++;
        tick;
        model_release(int'(e_idx));
        for (int k = 0; k < 5; k++) begin
            vectors += 5;
            if (resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid[%0d]: got %b, expected 1", k, resp_valid); end
            if (resp_idx !== e_idx) begin miscompares++; $display("[TB] FAIL bp_idx[%0d]: got %0d, expected %0d", k, resp_idx, e_idx); end
            if (resp_hit !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_hit[%0d]: got %b, expected 0", k, resp_hit); end
            if (resp_evict !== e_evict) begin miscompares++; $display("[TB] FAIL bp_evict[%0d]: got %b, expected %b", k, resp_evict, e_evict); end
            if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_req_ready[%0d]: got %b, expected 0", k, req_ready); end
            if (cam_we && cam_din_valid) writes++;
            tick;
            rel_valid = 1'b0;
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        vectors++;
        if (writes !== 1) begin miscompares++; $display("[TB] FAIL bp_write_pulses: got %0d, expected 1", writes); end
        model_request(8'hA5, e_idx, e_hit, e_evict, e_lat);
        issue_request(8'hA5, 0, 1'b0, '0, lat, idx, hit, evict);
        vectors += 3;
        if (hit !== e_hit) begin miscompares++; $display("[TB] FAIL bp_after_rel_hit: got %b, expected %b", hit, e_hit); end
        if (idx !== e_idx) begin miscompares++; $display("[TB] FAIL bp_after_rel_idx: got %0d, expected %0d", idx, e_idx); end
        if (lat !== e_lat) begin miscompares++; $display("[TB] FAIL bp_after_rel_lat: got %0d, expected %0d", lat, e_lat); end
    endtask

    task automatic test_reset_in_alloc;
        int lat, e_lat;
        logic [IW-1:0] idx, e_idx;
        logic hit, evict, e_hit, e_evict;
        logic [23:0] obs;
        req_key   = 8'hC3;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        vectors++;
        if (cam_we !== 1'b1) begin miscompares++; $display("[TB] FAIL ralloc_pre_we: got %b, expected 1", cam_we); end
        reset = 1'b1;
        #1;
        obs = {req_ready, resp_valid, cam_en, cam_we, cam_din, cam_din_valid, rel_ready,
               resp_idx, resp_hit, resp_evict, 6'd0};
        vectors++;
        if (obs !== 24'd0) begin miscompares++; $display("[TB] FAIL ralloc_outputs: got %h, expected 000000", obs); end
        tick;
        reset = 1'b0;
        tick;
        model_reset();
        model_request(8'h77, e_idx, e_hit, e_evict, e_lat);
        issue_request(8'h77, 0, 1'b0, '0, lat, idx, hit, evict);
        vectors += 4;
        if (lat !== e_lat) begin miscompares++; $display("[TB] FAIL ralloc_lat: got %0d, expected %0d", lat, e_lat); end
        if (idx !== e_idx) begin miscompares++; $display("[TB] FAIL ralloc_idx: got %0d, expected %0d", idx, e_idx); end
        if (hit !== e_hit) begin miscompares++; $display("[TB] FAIL ralloc_hit: got %b, expected %b", hit, e_hit); end
        if (evict !== e_evict) begin miscompares++; $display("[TB] FAIL ralloc_evict: got %b, expected %b", evict, e_evict); end
    endtask

    task automatic test_random;
        int lat, e_lat, delay;
        logic [IW-1:0] idx, e_idx, ri;
        logic hit, evict, e_hit, e_evict;
        logic [W-1:0] key;
        bit rel_en;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) do_release(IW'($urandom_range(0, DEPTH - 1)));
            key    = 8'h40 + W'($urandom_range(0, 6));
            delay  = $urandom_range(0, 3);
            rel_en = ($urandom_range(0, 3) == 0);
            ri     = IW'($urandom_range(0, DEPTH - 1));
            if (rel_en) model_release(int'(ri));
            model_request(key, e_idx, e_hit, e_evict, e_lat);
            issue_request(key, delay, rel_en, ri, lat, idx, hit, evict);
            vectors += 4;
            if (lat !== e_lat) begin miscompares++; $display("[TB] FAIL rand_lat[%0d]: got %0d, expected %0d", n, lat, e_lat); end
            if (idx !== e_idx) begin miscompares++; $display("[TB] FAIL rand_idx[%0d]: got %0d, expected %0d", n, idx, e_idx); end
            if (hit !== e_hit) begin miscompares++; $display("[TB] FAIL rand_hit[%0d]: got %b, expected %b", n, hit, e_hit); end
            if (evict !== e_evict) begin miscompares++; $display("[TB] FAIL rand_evict[%0d]: got %b, expected %b", n, evict, e_evict); end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        test_reset();
        test_first_alloc();
        test_fill_evict();
        test_release_victim();
        test_hit_cancel();
        test_backpressure();
        test_reset_in_alloc();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
